wb_stage_param: RTL and testbench
=================================

WB_STAGE_PARAM -- requirements
Module: wb_stage_param

Interface
REQ-001 Parameter DATA_W, default 16, data path width.
REQ-002 Parameter REG_AW, default 4, register-file address width.
REQ-003 Parameter CNT_W, default 16, retire-counter width.
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 rst_n  in  1  reset, synchronous, active-low.
REQ-006 in_valid  in  1  upstream (MEM stage) presents an instruction.
REQ-007 in_ready  out  1  stage accepts an instruction this cycle.
REQ-008 wb_sel  in  2  source select: 0 ALU, 1 MEM, 2 LINK, 3 IMM.
REQ-009 reg_we_in  in  1  instruction writes a register.
REQ-010 reg_rd_in  in  REG_AW  destination register.
REQ-011 alu_result, mem_read_data, link_addr, imm_data  in  DATA_W each  candidate write-back sources.
REQ-012 mem_data_valid  in  1  mem_read_data valid this cycle.
REQ-013 flush  in  1  discard any held or presented instruction.
REQ-014 rf_we  out  1  register-file write strobe (registered).
REQ-015 rf_waddr  out  REG_AW  register-file write address (registered).
REQ-016 rf_wdata  out  DATA_W  register-file write data (registered).
REQ-017 fwd_valid, fwd_addr (REG_AW), fwd_data (DATA_W)  out  forwarding copy of the pending commit, combinational from held state.
REQ-018 retire_cnt  out  CNT_W  count of committed register writes.

Function
REQ-019 FSM states IDLE and WAIT_MEM only.
REQ-020 IDLE: in_ready=1; WAIT_MEM: in_ready=0.
REQ-021 Accept = in_valid & in_ready & ~flush.
REQ-022 Accept with wb_sel!=1, or wb_sel==1 with mem_data_valid=1: selected source, reg_rd_in and effective write-enable are registered to rf_* on that edge; rf_we high exactly one cycle; state stays IDLE.
REQ-023 Accept with wb_sel==1 and mem_data_valid=0: capture rd and write-enable, go WAIT_MEM, rf_we=0.
REQ-024 WAIT_MEM with mem_data_valid=1 and flush=0: register mem_read_data to rf_wdata, pulse rf_we one cycle, return IDLE.
REQ-025 Effective write-enable = reg_we_in & (reg_rd_in != 0); writes to R0 are suppressed (rf_we stays 0) but the instruction still completes normally.
REQ-026 flush in IDLE: no accept, rf_we=0 next cycle; flush in WAIT_MEM: drop held op, return IDLE, rf_we=0; flush wins over simultaneous mem_data_valid.
REQ-027 mem_data_valid ignored in IDLE unless accompanying a wb_sel==1 accept.
REQ-028 fwd_valid=1 only in WAIT_MEM with held write-enable=1; fwd_addr=held rd; fwd_data=mem_read_data (consumer must also check mem_data_valid).
REQ-029 retire_cnt increments by 1 on every cycle rf_we is asserted; wraps modulo 2^CNT_W.
REQ-030 rf_waddr/rf_wdata hold their last values when rf_we=0.
REQ-031 Latency: accept to rf_we = 1 cycle; MEM-late case: mem_data_valid to rf_we = 1 cycle.

Reset
REQ-032 rst_n=0 at a clock edge: state IDLE, rf_we=0, rf_waddr=0, rf_wdata=0, retire_cnt=0, held rd/enable cleared.
REQ-033 Reset mid-WAIT_MEM abandons the held op; no write occurs after release.
REQ-034 in_ready=1 on the first cycle after rst_n returns to 1.

Structure
REQ-035 Shared package wb_pkg holds the wb_sel enum (WB_ALU, WB_MEM, WB_LINK, WB_IMM) and the FSM state enum.
REQ-036 Single module; no sub-modules; the source mux is an in-module combinational case on wb_sel.

Verification
REQ-037 ALU: in_valid=1, wb_sel=0, rd=3, alu_result=0x1234 -> next cycle rf_we=1, rf_waddr=3, rf_wdata=0x1234; retire_cnt=1.
REQ-038 Late load: wb_sel=1, rd=5, mem_data_valid=0 for 3 cycles then 1 with 0xBEEF -> in_ready=0 for those cycles, fwd_valid=1 with fwd_addr=5, rf_we=1 with 0xBEEF one cycle later.
REQ-039 R0: wb_sel=3, rd=0, imm=0x00FF -> rf_we stays 0, retire_cnt unchanged, in_ready stays 1.
REQ-040 Flush race: in WAIT_MEM assert flush and mem_data_valid together -> rf_we=0, state IDLE, in_ready=1 next cycle.
REQ-041 Wrap: CNT_W=4, 17 back-to-back LINK writes to rd=15 -> retire_cnt reads 1.
REQ-042 Reset in WAIT_MEM: rst_n=0 one cycle, then mem_data_valid=1 -> no rf_we, all outputs at reset values.

Source files
------------

// File: rtl/wb_stage_param_pkg.sv
// Purpose : shared types for the write-back stage (source select, FSM state).
// Latency : n/a (types only).
// Backpressure: n/a (types only).
package wb_pkg;

  // Write-back source select, encoding matches the wb_sel input.
  typedef enum logic [1:0] {
    WB_ALU  = 2'd0,
    WB_MEM  = 2'd1,
    WB_LINK = 2'd2,
    WB_IMM  = 2'd3
  } wb_sel_e;

  // IDLE accepts new work; WAIT_MEM holds a load whose data has not arrived.
  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_WAIT_MEM = 1'b1
  } wb_state_e;

endpackage : wb_pkg

// File: rtl/wb_stage_param_if.sv
// Purpose : bundle of MEM->WB handshake, candidate sources, RF write and forwarding signals.
// Latency : n/a (wiring only).
// Backpressure: in_ready is driven by the stage (slave) and honoured by the producer (master).
// Ports (slave view): in: in_valid, wb_sel, reg_we_in, reg_rd_in, alu_result, mem_read_data,
//   link_addr, imm_data, mem_data_valid, flush; out: in_ready, rf_we/waddr/wdata,
//   fwd_valid/addr/data, retire_cnt.
interface wb_stage_param_if #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 4,
  parameter int CNT_W  = 16
);
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        wb_sel;
  logic              reg_we_in;
  logic [REG_AW-1:0] reg_rd_in;
  logic [DATA_W-1:0] alu_result;
  logic [DATA_W-1:0] mem_read_data;
  logic [DATA_W-1:0] link_addr;
  logic [DATA_W-1:0] imm_data;
  logic              mem_data_valid;
  logic              flush;
  logic              rf_we;
  logic [REG_AW-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic              fwd_valid;
  logic [REG_AW-1:0] fwd_addr;
  logic [DATA_W-1:0] fwd_data;
  logic [CNT_W-1:0]  retire_cnt;

  // Stage side.
  modport slave (
    input  in_valid, wb_sel, reg_we_in, reg_rd_in, alu_result, mem_read_data,
           link_addr, imm_data, mem_data_valid, flush,
    output in_ready, rf_we, rf_waddr, rf_wdata, fwd_valid, fwd_addr, fwd_data, retire_cnt
  );

  // Producer / register-file side.
  modport master (
    output in_valid, wb_sel, reg_we_in, reg_rd_in, alu_result, mem_read_data,
           link_addr, imm_data, mem_data_valid, flush,
    input  in_ready, rf_we, rf_waddr, rf_wdata, fwd_valid, fwd_addr, fwd_data, retire_cnt
  );
endinterface : wb_stage_param_if

// File: rtl/wb_stage_param.sv
// Purpose : write-back stage; selects the result source and commits it to the register file.
// Latency : 1 cycle accept->rf_we; late load 1 cycle mem_data_valid->rf_we.
// Backpressure: in_ready drops while a load waits for its data; flush drops held/presented work.
// Ports: clk, rst_n (sync, active-low); wb = wb_stage_param_if.slave carrying all other signals.
module wb_stage_param #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 4,
  parameter int CNT_W  = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  wb_stage_param_if.slave wb
);
  import wb_pkg::*;

  wb_state_e         r_state;
  logic [REG_AW-1:0] r_hold_rd;
  logic              r_hold_we;
  logic              r_rf_we;
  logic [REG_AW-1:0] r_rf_waddr;
  logic [DATA_W-1:0] r_rf_wdata;
  logic [CNT_W-1:0]  r_retire_cnt;

  wb_sel_e           w_sel;
  logic              w_idle;
  logic              w_accept;
  logic              w_we_eff;
  logic [DATA_W-1:0] w_src;
  logic              w_fast;
  logic              w_go_wait;
  logic              w_late;
  logic              w_commit;
  logic [REG_AW-1:0] w_commit_addr;
  logic [DATA_W-1:0] w_commit_data;

  assign w_sel    = wb_sel_e'(wb.wb_sel);
  assign w_idle   = (r_state == ST_IDLE);
  assign w_accept = wb.in_valid & w_idle & ~wb.flush;
  // R0 is hard-wired zero: the instruction retires but never strobes the RF.
  assign w_we_eff = wb.reg_we_in & (wb.reg_rd_in != '0);

  always_comb begin
    w_src = wb.alu_result;
    case (w_sel)
      WB_ALU:  w_src = wb.alu_result;
      WB_MEM:  w_src = wb.mem_read_data;
      WB_LINK: w_src = wb.link_addr;
      WB_IMM:  w_src = wb.imm_data;
      default: w_src = wb.alu_result;
    endcase
  end

  // A load whose data is already valid completes like any other source.
  assign w_fast    = w_accept & ((w_sel != WB_MEM) | wb.mem_data_valid);
  assign w_go_wait = w_accept & (w_sel == WB_MEM) & ~wb.mem_data_valid;
  // Flush beats a simultaneous data return.
  assign w_late    = (r_state == ST_WAIT_MEM) & ~wb.flush & wb.mem_data_valid;

  assign w_commit      = (w_fast & w_we_eff) | (w_late & r_hold_we);
  assign w_commit_addr = w_late ? r_hold_rd : wb.reg_rd_in;
  assign w_commit_data = w_late ? wb.mem_read_data : w_src;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_hold_rd    <= '0;
      r_hold_we    <= 1'b0;
      r_rf_we      <= 1'b0;
      r_rf_waddr   <= '0;
      r_rf_wdata   <= '0;
      r_retire_cnt <= '0;
    end else begin
      r_rf_we <= w_commit;
      // Address/data only move on a real write so the RF port holds its last commit.
      if (w_commit) begin
        r_rf_waddr   <= w_commit_addr;
        r_rf_wdata   <= w_commit_data;
        r_retire_cnt <= r_retire_cnt + CNT_W'(1);
      end
      case (r_state)
        ST_IDLE: begin
          if (w_go_wait) begin
            r_state   <= ST_WAIT_MEM;
            r_hold_rd <= wb.reg_rd_in;
            r_hold_we <= w_we_eff;
          end
        end
        ST_WAIT_MEM: begin
          if (wb.flush | wb.mem_data_valid) begin
            r_state   <= ST_IDLE;
            r_hold_rd <= '0;
            r_hold_we <= 1'b0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign wb.in_ready   = w_idle;
  assign wb.rf_we      = r_rf_we;
  assign wb.rf_waddr   = r_rf_waddr;
  assign wb.rf_wdata   = r_rf_wdata;
  assign wb.retire_cnt = r_retire_cnt;
  // Forwarding advertises the pending load; data is only meaningful with mem_data_valid.
  assign wb.fwd_valid  = (r_state == ST_WAIT_MEM) & r_hold_we;
  assign wb.fwd_addr   = r_hold_rd;
  assign wb.fwd_data   = wb.mem_read_data;

endmodule : wb_stage_param

// File: tb/tb_wb_stage_param.sv
// Purpose : self-checking bench for wb_stage_param (directed scenarios + randomized model compare).
// Latency : n/a.
// Backpressure: n/a.
module tb_wb_stage_param;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  wb_stage_param_if #(.DATA_W(16), .REG_AW(4), .CNT_W(16)) b0 ();
  wb_stage_param_if #(.DATA_W(16), .REG_AW(4), .CNT_W(4))  b1 ();

  wb_stage_param #(.DATA_W(16), .REG_AW(4), .CNT_W(16)) u0 (.clk(clk), .rst_n(rst_n), .wb(b0));
  wb_stage_param #(.DATA_W(16), .REG_AW(4), .CNT_W(4))  u1 (.clk(clk), .rst_n(rst_n), .wb(b1));

  int checks = 0;
  int errors = 0;

  // Reference model of u0: "is a load outstanding" plus the last committed write.
  bit          m_busy = 0;
  bit          m_en   = 0;
  logic [3:0]  m_rd   = '0;
  logic        m_we   = 1'b0;
  logic [3:0]  m_addr = '0;
  logic [15:0] m_data = '0;
  logic [15:0] m_cnt  = '0;

  task automatic model_edge();
    logic [15:0] src [4];
    bit          commit;
    logic [3:0]  caddr;
    logic [15:0] cdata;
    src[0] = b0.alu_result; src[1] = b0.mem_read_data;
    src[2] = b0.link_addr;  src[3] = b0.imm_data;
    commit = 0; caddr = '0; cdata = '0;
    if (!rst_n) begin
      m_busy = 0; m_en = 0; m_rd = '0; m_we = 0; m_addr = '0; m_data = '0; m_cnt = '0;
    end else begin
      if (!m_busy) begin
        if (b0.in_valid && !b0.flush) begin
          if (b0.wb_sel == 2'd1 && !b0.mem_data_valid) begin
            m_busy = 1; m_rd = b0.reg_rd_in; m_en = b0.reg_we_in && (b0.reg_rd_in != 0);
          end else if (b0.reg_we_in && b0.reg_rd_in != 0) begin
            commit = 1; caddr = b0.reg_rd_in; cdata = src[b0.wb_sel];
          end
        end
      end else if (b0.flush) begin
        m_busy = 0; m_en = 0;
      end else if (b0.mem_data_valid) begin
        if (m_en) begin commit = 1; caddr = m_rd; cdata = b0.mem_read_data; end
        m_busy = 0; m_en = 0;
      end
      m_we = commit;
      if (commit) begin m_addr = caddr; m_data = cdata; m_cnt = m_cnt + 16'd1; end
    end
  endtask

  // Advance one clock; leaves the bench 1 time unit after the rising edge.
  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic idle0();
    b0.in_valid = 0; b0.flush = 0; b0.mem_data_valid = 0; b0.reg_we_in = 0;
    b0.wb_sel = 2'd0; b0.reg_rd_in = '0;
  endtask

  task automatic issue0(input logic [1:0] sel, input logic [3:0] rd, input logic mdv);
    b0.in_valid = 1; b0.flush = 0; b0.reg_we_in = 1; b0.wb_sel = sel;
    b0.reg_rd_in = rd; b0.mem_data_valid = mdv;
  endtask

  task automatic test_reset();
    idle0();
    rst_n = 0; tick(); tick(); rst_n = 1;
    checks++; if (b0.rf_we !== 1'b0) begin errors++; $display("FAIL reset_we got %0b exp 0", b0.rf_we); end
    checks++; if (b0.rf_waddr !== 4'd0) begin errors++; $display("FAIL reset_waddr got %0d exp 0", b0.rf_waddr); end
    checks++; if (b0.rf_wdata !== 16'd0) begin errors++; $display("FAIL reset_wdata got %h exp 0000", b0.rf_wdata); end
    checks++; if (b0.retire_cnt !== 16'd0) begin errors++; $display("FAIL reset_cnt got %0d exp 0", b0.retire_cnt); end
    checks++; if (b0.in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %0b exp 1", b0.in_ready); end
    checks++; if (b0.fwd_valid !== 1'b0) begin errors++; $display("FAIL reset_fwd got %0b exp 0", b0.fwd_valid); end
  endtask

  task automatic test_alu();
    issue0(2'd0, 4'd3, 1'b0);
    b0.alu_result = 16'h1234; b0.imm_data = 16'h9999; b0.link_addr = 16'h7777;
    tick(); idle0();
    checks++; if (b0.rf_we !== 1'b1) begin errors++; $display("FAIL alu_we got %0b exp 1", b0.rf_we); end
    checks++; if (b0.rf_waddr !== 4'd3) begin errors++; $display("FAIL alu_waddr got %0d exp 3", b0.rf_waddr); end
    checks++; if (b0.rf_wdata !== 16'h1234) begin errors++; $display("FAIL alu_wdata got %h exp 1234", b0.rf_wdata); end
    checks++; if (b0.retire_cnt !== 16'd1) begin errors++; $display("FAIL alu_cnt got %0d exp 1", b0.retire_cnt); end
    tick();
    checks++; if (b0.rf_we !== 1'b0) begin errors++; $display("FAIL alu_pulse got %0b exp 0", b0.rf_we); end
    checks++; if (b0.rf_waddr !== 4'd3) begin errors++; $display("FAIL alu_hold_addr got %0d exp 3", b0.rf_waddr); end
  endtask

  task automatic test_late_load();
    issue0(2'd1, 4'd5, 1'b0);
    b0.mem_read_data = 16'h0bad;
    tick(); idle0();
    for (int i = 0; i < 3; i++) begin
      checks++; if (b0.in_ready !== 1'b0) begin errors++; $display("FAIL late_ready[%0d] got %0b exp 0", i, b0.in_ready); end
      checks++; if (b0.fwd_valid !== 1'b1 || b0.fwd_addr !== 4'd5) begin
        errors++; $display("FAIL late_fwd[%0d] got v=%0b a=%0d exp v=1 a=5", i, b0.fwd_valid, b0.fwd_addr); end
      checks++; if (b0.rf_we !== 1'b0) begin errors++; $display("FAIL late_early_we[%0d] got %0b exp 0", i, b0.rf_we); end
      tick();
    end
    b0.mem_data_valid = 1; b0.mem_read_data = 16'hBEEF; #1;
    checks++; if (b0.fwd_data !== 16'hBEEF) begin errors++; $display("FAIL late_fwd_data got %h exp beef", b0.fwd_data); end
    tick(); idle0();
    checks++; if (b0.rf_we !== 1'b1 || b0.rf_waddr !== 4'd5 || b0.rf_wdata !== 16'hBEEF) begin
      errors++; $display("FAIL late_commit got we=%0b a=%0d d=%h exp we=1 a=5 d=beef", b0.rf_we, b0.rf_waddr, b0.rf_wdata); end
    checks++; if (b0.retire_cnt !== 16'd2) begin errors++; $display("FAIL late_cnt got %0d exp 2", b0.retire_cnt); end
    checks++; if (b0.in_ready !== 1'b1) begin errors++; $display("FAIL late_ready_back got %0b exp 1", b0.in_ready); end
  endtask

  task automatic test_r0();
    issue0(2'd3, 4'd0, 1'b0);
    b0.imm_data = 16'h00FF;
    tick(); idle0();
    checks++; if (b0.rf_we !== 1'b0) begin errors++; $display("FAIL r0_we got %0b exp 0", b0.rf_we); end
    checks++; if (b0.retire_cnt !== 16'd2) begin errors++; $display("FAIL r0_cnt got %0d exp 2", b0.retire_cnt); end
    checks++; if (b0.in_ready !== 1'b1) begin errors++; $display("FAIL r0_ready got %0b exp 1", b0.in_ready); end
    checks++; if (b0.rf_wdata !== 16'hBEEF) begin errors++; $display("FAIL r0_hold got %h exp beef", b0.rf_wdata); end
    // Load to R0: completes through WAIT_MEM but never forwards or writes.
    issue0(2'd1, 4'd0, 1'b0);
    tick(); idle0();
    checks++; if (b0.in_ready !== 1'b0 || b0.fwd_valid !== 1'b0) begin
      errors++; $display("FAIL r0_load_wait got rdy=%0b fwd=%0b exp rdy=0 fwd=0", b0.in_ready, b0.fwd_valid); end
    b0.mem_data_valid = 1; b0.mem_read_data = 16'h4444;
    tick(); idle0();
    checks++; if (b0.rf_we !== 1'b0 || b0.in_ready !== 1'b1) begin
      errors++; $display("FAIL r0_load_done got we=%0b rdy=%0b exp we=0 rdy=1", b0.rf_we, b0.in_ready); end
  endtask

  task automatic test_flush();
    issue0(2'd1, 4'd7, 1'b0);
    tick(); idle0();
    checks++; if (b0.in_ready !== 1'b0) begin errors++; $display("FAIL flush_wait got %0b exp 0", b0.in_ready); end
    b0.flush = 1; b0.mem_data_valid = 1; b0.mem_read_data = 16'h5555;
    tick(); idle0();
    checks++; if (b0.rf_we !== 1'b0) begin errors++; $display("FAIL flush_race_we got %0b exp 0", b0.rf_we); end
    checks++; if (b0.in_ready !== 1'b1 || b0.fwd_valid !== 1'b0) begin
      errors++; $display("FAIL flush_race_state got rdy=%0b fwd=%0b exp rdy=1 fwd=0", b0.in_ready, b0.fwd_valid); end
    // Flush while idle blocks the presented instruction.
    issue0(2'd0, 4'd4, 1'b0); b0.flush = 1; b0.alu_result = 16'h4321;
    tick(); idle0();
    checks++; if (b0.rf_we !== 1'b0 || b0.retire_cnt !== 16'd2) begin
      errors++; $display("FAIL flush_idle got we=%0b cnt=%0d exp we=0 cnt=2", b0.rf_we, b0.retire_cnt); end
    // Stray data-valid in IDLE with nothing presented is ignored.
    b0.mem_data_valid = 1;
    tick(); idle0();
    checks++; if (b0.rf_we !== 1'b0) begin errors++; $display("FAIL idle_mdv got %0b exp 0", b0.rf_we); end
  endtask

  task automatic test_reset_in_wait();
    issue0(2'd1, 4'd9, 1'b0);
    tick(); idle0();
    rst_n = 0; tick(); rst_n = 1;
    b0.mem_data_valid = 1; b0.mem_read_data = 16'hAAAA;
    tick(); idle0();
    checks++; if (b0.rf_we !== 1'b0 || b0.rf_waddr !== 4'd0 || b0.rf_wdata !== 16'd0) begin
      errors++; $display("FAIL rst_wait_rf got we=%0b a=%0d d=%h exp 0/0/0000", b0.rf_we, b0.rf_waddr, b0.rf_wdata); end
    checks++; if (b0.retire_cnt !== 16'd0 || b0.in_ready !== 1'b1 || b0.fwd_valid !== 1'b0) begin
      errors++; $display("FAIL rst_wait_state got cnt=%0d rdy=%0b fwd=%0b exp 0/1/0", b0.retire_cnt, b0.in_ready, b0.fwd_valid); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      rst_n             = ($urandom_range(0, 79) != 0);
      b0.in_valid       = ($urandom_range(0, 9) < 7);
      b0.wb_sel         = 2'($urandom_range(0, 3));
      b0.reg_we_in      = ($urandom_range(0, 9) < 8);
      b0.reg_rd_in      = 4'($urandom_range(0, 15));
      b0.alu_result     = 16'($urandom);
      b0.mem_read_data  = 16'($urandom);
      b0.link_addr      = 16'($urandom);
      b0.imm_data       = 16'($urandom);
      b0.mem_data_valid = ($urandom_range(0, 1) == 1);
      b0.flush          = ($urandom_range(0, 7) == 0);
      tick();
      checks++; if (b0.rf_we !== m_we || b0.rf_waddr !== m_addr || b0.rf_wdata !== m_data) begin
        errors++; $display("FAIL rand_rf[%0d] got we=%0b a=%0d d=%h exp we=%0b a=%0d d=%h",
                           n, b0.rf_we, b0.rf_waddr, b0.rf_wdata, m_we, m_addr, m_data); end
      checks++; if (b0.retire_cnt !== m_cnt) begin
        errors++; $display("FAIL rand_cnt[%0d] got %0d exp %0d", n, b0.retire_cnt, m_cnt); end
      checks++; if (b0.in_ready !== !m_busy || b0.fwd_valid !== (m_busy && m_en)) begin
        errors++; $display("FAIL rand_ctl[%0d] got rdy=%0b fwd=%0b exp rdy=%0b fwd=%0b",
                           n, b0.in_ready, b0.fwd_valid, !m_busy, m_busy && m_en); end
      if (m_busy && m_en) begin
        checks++; if (b0.fwd_addr !== m_rd) begin
          errors++; $display("FAIL rand_fwd_addr[%0d] got %0d exp %0d", n, b0.fwd_addr, m_rd); end
      end
    end
    rst_n = 1; idle0(); tick();
  endtask

  task automatic test_wrap();
    rst_n = 0; tick(); rst_n = 1;
    for (int i = 0; i < 17; i++) begin
      b1.in_valid = 1; b1.wb_sel = 2'd2; b1.reg_we_in = 1; b1.reg_rd_in = 4'd15;
      b1.link_addr = 16'h0100 + 16'(i);
      tick();
      checks++; if (b1.retire_cnt !== 4'((i + 1) % 16) || b1.in_ready !== 1'b1) begin
        errors++; $display("FAIL wrap_cnt[%0d] got cnt=%0d rdy=%0b exp cnt=%0d rdy=1",
                           i, b1.retire_cnt, b1.in_ready, (i + 1) % 16); end
    end
    b1.in_valid = 0;
    tick();
    checks++; if (b1.retire_cnt !== 4'd1 || b1.rf_waddr !== 4'd15 || b1.rf_wdata !== 16'h0110) begin
      errors++; $display("FAIL wrap_final got cnt=%0d a=%0d d=%h exp cnt=1 a=15 d=0110",
                         b1.retire_cnt, b1.rf_waddr, b1.rf_wdata); end
  endtask

  initial begin
    idle0();
    b0.alu_result = '0; b0.mem_read_data = '0; b0.link_addr = '0; b0.imm_data = '0;
    b1.in_valid = 0; b1.flush = 0; b1.mem_data_valid = 0; b1.reg_we_in = 0; b1.wb_sel = 2'd0;
    b1.reg_rd_in = '0; b1.alu_result = '0; b1.mem_read_data = '0; b1.link_addr = '0; b1.imm_data = '0;
    test_reset();
    test_alu();
    test_late_load();
    test_r0();
    test_flush();
    test_reset_in_wait();
    test_random();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got no finish by 1ms exp finish");
    $fatal(1, "watchdog");
  end

endmodule : tb_wb_stage_param
